psx_controller_emu: RTL and testbench

//  Device-side PSX digital pad: answers a console's att/psx_clk/cmd poll with ID
//  and button bytes on data, and pulses ack after each byte except the last.

---
 rtl/psx_controller_emu.sv | 231 +++++++++++++++++++++++
 tb/tb_psx_controller_emu.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/psx_controller_emu.sv
// Device-side PSX pad emulator: oversamples att/psx_clk/cmd, shifts ID and button bytes out on data.
// Define PSX_DUALSHOCK_EN to answer as an analog pad (ID 0x73, four extra stick bytes).
module psx_controller_emu #(
    parameter int SYNC_STAGES = 2,
    parameter int ACK_DELAY   = 200,
    parameter int ACK_WIDTH   = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        att,
    input  logic        psx_clk,
    input  logic        cmd,
    input  logic [15:0] buttons,
    input  logic [31:0] sticks,
    output logic        data,
    output logic        ack,
    output logic        busy,
    output logic [7:0]  rx_byte,
    output logic        rx_valid
);

    localparam int CNT_MAX = (ACK_DELAY > ACK_WIDTH) ? ACK_DELAY : ACK_WIDTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

`ifdef PSX_DUALSHOCK_EN
    localparam logic [3:0] LAST_IDX = 4'd8;
    localparam logic [7:0] ID_BYTE  = 8'h73;
`else
    localparam logic [3:0] LAST_IDX = 4'd4;
    localparam logic [7:0] ID_BYTE  = 8'h41;
`endif

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        ACK_WAIT,
        ACK_PULSE,
        IGNORE,
        DONE
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] att_sr, pclk_sr, cmd_sr;
    logic                   att_s, pclk_s, cmd_s;
    logic                   att_d, pclk_d;
    logic                   att_fall, att_rise, pclk_fall, pclk_rise;

    logic [7:0]       rx_sh, rx_next, tx_byte;
    logic [2:0]       bit_idx;
    logic [3:0]       byte_idx;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      snap_btn;
    logic             byte_done, bad_hdr, delay_done, width_done;

`ifdef PSX_DUALSHOCK_EN
    logic [31:0]      snap_stk;
`else
    logic             sticks_unused;
    assign sticks_unused = ^sticks;
`endif

    // The att chain resets to "selected" so a frame already running when rst
    // drops never produces a falling edge; only a fresh high->low select starts one.
    always_ff @(posedge clk) begin
        if (rst) begin
            att_sr  <= '0;
            pclk_sr <= '1;
            cmd_sr  <= '1;
            att_d   <= 1'b0;
            pclk_d  <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples the pre-edge value of its neighbour, which a shift chain needs.
            att_sr  <= {att_sr[SYNC_STAGES-2:0], att};
            pclk_sr <= {pclk_sr[SYNC_STAGES-2:0], psx_clk};
            cmd_sr  <= {cmd_sr[SYNC_STAGES-2:0], cmd};
            att_d   <= att_s;
            pclk_d  <= pclk_s;
        end
    end

    assign att_s     = att_sr[SYNC_STAGES-1];
    assign pclk_s    = pclk_sr[SYNC_STAGES-1];
    assign cmd_s     = cmd_sr[SYNC_STAGES-1];
    assign att_fall  = att_d & ~att_s;
    assign att_rise  = ~att_d & att_s;
    assign pclk_fall = pclk_d & ~pclk_s;
    assign pclk_rise = ~pclk_d & pclk_s;

    assign byte_done  = (state == SHIFT) && pclk_rise && (bit_idx == 3'd7);
    assign bad_hdr    = ((byte_idx == 4'd0) && (rx_next != 8'h01)) ||
                        ((byte_idx == 4'd1) && (rx_next != 8'h42));
    assign delay_done = (cnt == CNT_W'(ACK_DELAY - 1));
    assign width_done = (cnt == CNT_W'(ACK_WIDTH - 1));

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned (which would infer a latch).
        rx_next          = rx_sh;
        rx_next[bit_idx] = cmd_s;
    end

    always_comb begin
        tx_byte = 8'hFF;
        case (byte_idx)
            4'd0:    tx_byte = 8'hFF;
            4'd1:    tx_byte = ID_BYTE;
            4'd2:    tx_byte = 8'h5A;
            4'd3:    tx_byte = snap_btn[7:0];
            4'd4:    tx_byte = snap_btn[15:8];
`ifdef PSX_DUALSHOCK_EN
            4'd5:    tx_byte = snap_stk[7:0];
            4'd6:    tx_byte = snap_stk[15:8];
            4'd7:    tx_byte = snap_stk[23:16];
            4'd8:    tx_byte = snap_stk[31:24];
`endif
            default: tx_byte = 8'hFF;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (att_fall) state_next = SHIFT;
            SHIFT: begin
                if (byte_done) begin
                    if (bad_hdr)                    state_next = IGNORE;
                    else if (byte_idx == LAST_IDX)  state_next = DONE;
                    else                            state_next = ACK_WAIT;
                end
            end
            ACK_WAIT:  if (delay_done) state_next = ACK_PULSE;
            ACK_PULSE: if (width_done) state_next = SHIFT;
            IGNORE:    state_next = IGNORE;
            DONE:      state_next = DONE;
            default:   state_next = IDLE;
        endcase
        // Deselect wins over everything, including a frame stuck mid-ack.
        if (att_rise) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data     <= 1'b1;
            ack      <= 1'b1;
            busy     <= 1'b0;
            rx_byte  <= 8'h00;
            rx_valid <= 1'b0;
            rx_sh    <= 8'h00;
            bit_idx  <= 3'd0;
            byte_idx <= 4'd0;
            cnt      <= '0;
            snap_btn <= 16'hFFFF;
`ifdef PSX_DUALSHOCK_EN
            snap_stk <= 32'h8080_8080;
`endif
        end else begin
            rx_valid <= 1'b0;
            if (att_rise) begin
                data     <= 1'b1;
                ack      <= 1'b1;
                busy     <= 1'b0;
                bit_idx  <= 3'd0;
                byte_idx <= 4'd0;
                cnt      <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (att_fall) begin
                            snap_btn <= buttons;
`ifdef PSX_DUALSHOCK_EN
                            snap_stk <= sticks;
`endif
                            busy     <= 1'b1;
                            data     <= 1'b1;
                            ack      <= 1'b1;
                            bit_idx  <= 3'd0;
                            byte_idx <= 4'd0;
                        end
                    end
                    SHIFT: begin
                        if (pclk_fall) begin
                            data <= tx_byte[bit_idx];
                        end else if (pclk_rise) begin
                            rx_sh <= rx_next;
                            if (bit_idx == 3'd7) begin
                                bit_idx  <= 3'd0;
                                rx_byte  <= rx_next;
                                rx_valid <= 1'b1;
                                cnt      <= '0;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end
                    end
                    ACK_WAIT: begin
                        data <= 1'b1;
                        if (delay_done) begin
                            ack <= 1'b0;
                            cnt <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ACK_PULSE: begin
                        if (width_done) begin
                            ack      <= 1'b1;
                            cnt      <= '0;
                            bit_idx  <= 3'd0;
                            byte_idx <= (byte_idx == LAST_IDX) ? byte_idx : byte_idx + 4'd1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    IGNORE, DONE: begin
                        data <= 1'b1;
                        ack  <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_psx_controller_emu.sv
// Directed bench for psx_controller_emu acting as the console side of the PSX bus.
// Build with PSX_DUALSHOCK_EN defined to exercise the 9-byte analog frame.
module tb_psx_controller_emu;

    localparam int SYNC = 2;
    localparam int ADLY = 40;
    localparam int AWID = 20;
    localparam int H    = 8;   // psx_clk half period in clk cycles
`ifdef PSX_DUALSHOCK_EN
    localparam int NB = 9;
`else
    localparam int NB = 5;
`endif

    logic        clk = 1'b0;
    logic        rst, att, psx_clk, cmd;
    logic [15:0] buttons;
    logic [31:0] sticks;
    logic        data, ack, busy, rx_valid;
    logic [7:0]  rx_byte;

    int checks = 0;
    int errors = 0;
    int rv_count = 0;
    int ack_pulses = 0;

    psx_controller_emu #(
        .SYNC_STAGES(SYNC),
        .ACK_DELAY  (ADLY),
        .ACK_WIDTH  (AWID)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .att     (att),
        .psx_clk (psx_clk),
        .cmd     (cmd),
        .buttons (buttons),
        .sticks  (sticks),
        .data    (data),
        .ack     (ack),
        .busy    (busy),
        .rx_byte (rx_byte),
        .rx_valid(rx_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rx_valid === 1'b1) rv_count++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_resp(input int idx, input logic [15:0] b, input logic [31:0] s);
        case (idx)
            0:       return 8'hFF;
`ifdef PSX_DUALSHOCK_EN
            1:       return 8'h73;
`else
            1:       return 8'h41;
`endif
            2:       return 8'h5A;
            3:       return b[7:0];
            4:       return b[15:8];
            5:       return s[7:0];
            6:       return s[15:8];
            7:       return s[23:16];
            8:       return s[31:24];
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] exp_cmd(input int idx);
        case (idx)
            0:       return 8'h01;
            1:       return 8'h42;
            default: return 8'h00;
        endcase
    endfunction

    // Shift nbits LSB first; returns right after driving the last rising edge.
    task automatic xfer(input logic [7:0] c, input int nbits, output logic [7:0] d);
        d = 8'hFF;
        for (int i = 0; i < nbits; i++) begin
            psx_clk = 1'b0;
            cmd     = c[i];
            tick(H);
            d[i]    = data;
            psx_clk = 1'b1;
            if (i < nbits - 1) tick(H);
        end
    endtask

    // Called right after the 8th rising edge. Ack falls after the synchronizer,
    // the edge-detect register and ACK_DELAY counted cycles.
    task automatic ack_phase(input string tag, input bit expect_ack);
        int n = 0;
        int m = 0;
        while (ack === 1'b1 && n < ADLY + SYNC + 20) begin
            tick(1);
            n++;
        end
        if (ack === 1'b0) ack_pulses++;
        if (expect_ack) begin
            check({tag, "_dly"}, n, ADLY + SYNC + 1);
            while (ack === 1'b0 && m < AWID + 10) begin
                tick(1);
                m++;
            end
            check({tag, "_wid"}, m, AWID);
        end else begin
            check({tag, "_noack"}, ack, 1'b1);
        end
    endtask

    task automatic frame(input string tag, input logic [15:0] b0, input int chg_byte, input logic [15:0] chg_val);
        logic [7:0] d;
        int rv0;
        buttons    = b0;
        ack_pulses = 0;
        rv0        = rv_count;
        att        = 1'b0;
        tick(2 * H);
        check({tag, "_busy"}, busy, 1'b1);
        for (int k = 0; k < NB; k++) begin
            if (k == chg_byte) buttons = chg_val;
            xfer(exp_cmd(k), 8, d);
            check($sformatf("%s_b%0d", tag, k), d, exp_resp(k, b0, sticks));
            ack_phase($sformatf("%s_a%0d", tag, k), k < NB - 1);
        end
        check({tag, "_acks"}, ack_pulses, NB - 1);
        check({tag, "_rxv"}, rv_count - rv0, NB);
        att = 1'b1;
        tick(2 * H);
        check({tag, "_idle"}, {busy, data, ack}, 3'b011);
    endtask

    initial begin
        logic [7:0] d;
        rst     = 1'b1;
        att     = 1'b1;
        psx_clk = 1'b1;
        cmd     = 1'b1;
        buttons = 16'hFFFF;
        sticks  = 32'h80807F7F;

        // Reset values
        tick(3);
        check("rst_data", data, 1'b1);
        check("rst_ack", ack, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_rxv", rx_valid, 1'b0);
        check("rst_rxb", rx_byte, 8'h00);
        rst = 1'b0;
        tick(4);

        // Plain poll
        frame("dig", 16'hFFFE, -1, 16'h0000);

        // Bad start byte: ignored until deselect
        att = 1'b0;
        tick(2 * H);
        xfer(8'h81, 8, d);
        tick(SYNC + 1);
        check("bad_rxb", rx_byte, 8'h81);
        ack_phase("bad_a0", 1'b0);
        xfer(8'h42, 8, d);
        check("bad_b1", d, 8'hFF);
        ack_phase("bad_a1", 1'b0);
        check("bad_busy", busy, 1'b1);
        att = 1'b1;
        tick(2 * H);
        frame("post_bad", 16'h1234, -1, 16'h0000);

        // Wrong command in byte 1
        att = 1'b0;
        tick(2 * H);
        xfer(8'h01, 8, d);
        ack_phase("id_a0", 1'b1);
        xfer(8'h43, 8, d);
        check("id_b1", d, exp_resp(1, 16'h0, 32'h0));
        tick(SYNC + 1);
        check("id_rxb", rx_byte, 8'h43);
        ack_phase("id_a1", 1'b0);
        att = 1'b1;
        tick(2 * H);

        // Abort three bits into byte 2 (0x5A: bits 0..2 = 0,1,0)
        att = 1'b0;
        tick(2 * H);
        xfer(8'h01, 8, d);
        ack_phase("abt_a0", 1'b1);
        xfer(8'h42, 8, d);
        ack_phase("abt_a1", 1'b1);
        xfer(8'h00, 3, d);
        check("abt_part", d[2:0], 3'b010);
        att = 1'b1;
        tick(SYNC + 1);
        check("abt_busy", busy, 1'b0);
        check("abt_data", data, 1'b1);
        tick(2 * H);
        frame("post_abt", 16'hBD7E, -1, 16'h0000);

        // Reset mid-frame: the running frame must not be joined
        att = 1'b0;
        tick(2 * H);
        xfer(8'h01, 8, d);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(4);
        check("rstm_busy", busy, 1'b0);
        xfer(8'h42, 8, d);
        check("rstm_b1", d, 8'hFF);
        ack_phase("rstm_a1", 1'b0);
        check("rstm_busy2", busy, 1'b0);
        att = 1'b1;
        tick(2 * H);

        // Snapshot: buttons cleared during byte 2 must not reach bytes 3/4
        frame("snap", 16'hA55A, 2, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
